onchip_mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port on-chip program/data RAM (32-bit words, 15-bit word address, byte enables, 1-cycle read latency) between the Nios II data master (m0) and the three-phase sample-capture writer (m1). It serialises both requesters onto the one RAM port at no more than one command per cycle. It applies burst-limited round-robin arbitration and routes read data back to the issuing requester with a fixed 1-cycle latency.

---
 rtl/onchip_mem_arbiter_if.sv | 26 ++
 rtl/onchip_mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_onchip_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/onchip_mem_arbiter_if.sv
// rtl/onchip_mem_arbiter_if.sv - requester-side RAM command/read-return bus
// master drives commands into the arbiter; slave is the arbiter side.
interface onchip_mem_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W / 8
) ();
  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// rtl/onchip_mem_arbiter.sv - two-requester arbiter for the single-port on-chip RAM
// MEMARB_FIXED_PRIO_EN selects strict m1 priority instead of burst-limited round-robin.
module onchip_mem_arbiter #(
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 32,
  parameter int BE_W      = DATA_W / 8,
  parameter int MAX_BURST = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  onchip_mem_arbiter_if.slave  m0,
  onchip_mem_arbiter_if.slave  m1,
  output logic [ADDR_W-1:0]    mem_address,
  output logic [BE_W-1:0]      mem_byteenable,
  output logic                 mem_chipselect,
  output logic                 mem_write,
  output logic [DATA_W-1:0]    mem_writedata,
  input  logic [DATA_W-1:0]    mem_readdata
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t state, state_d;
  logic   req0, req1;
  logic   grant0, grant1;
  logic   rd_pend, rd_id;

  // Gating requests with reset keeps the RAM port quiet while reset is held.
  assign req0 = reset_n & (m0.read | m0.write);
  assign req1 = reset_n & (m1.read | m1.write);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

`ifdef MEMARB_FIXED_PRIO_EN
  always_comb begin
    grant1  = req1;
    grant0  = req0 & ~req1;
    state_d = IDLE;
    if (req1)      state_d = OWN1;
    else if (req0) state_d = OWN0;
  end
`else
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  logic [7:0] cnt, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= '0;
    else          cnt <= cnt_d;
  end

  always_comb begin
    grant0  = 1'b0;
    grant1  = 1'b0;
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (req1) begin
          grant1  = 1'b1;
          state_d = OWN1;
          // A contested grant out of IDLE is the first beat of m1's burst.
          if (req0) begin
            if (BURST_LAST == 8'd0) state_d = OWN0;
            else                    cnt_d   = 8'd1;
          end
        end else if (req0) begin
          grant0  = 1'b1;
          state_d = OWN0;
        end
      end
      OWN0: begin
        if (req0 && req1) begin
          grant0 = 1'b1;
          if (cnt == BURST_LAST) begin
            state_d = OWN1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + 8'd1;
          end
        end else if (req0) begin
          grant0 = 1'b1;
          cnt_d  = '0;
        end else if (req1) begin
          grant1  = 1'b1;
          state_d = OWN1;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      OWN1: begin
        if (req0 && req1) begin
          grant1 = 1'b1;
          if (cnt == BURST_LAST) begin
            state_d = OWN0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + 8'd1;
          end
        end else if (req1) begin
          grant1 = 1'b1;
          cnt_d  = '0;
        end else if (req0) begin
          grant0  = 1'b1;
          state_d = OWN0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
`endif

  always_comb begin
    mem_chipselect = grant0 | grant1;
    mem_address    = '0;
    mem_byteenable = '0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    if (grant1) begin
      mem_address    = m1.address;
      mem_write      = m1.write;
      mem_byteenable = m1.write ? m1.byteenable : '1;
      mem_writedata  = m1.writedata;
    end else if (grant0) begin
      mem_address    = m0.address;
      mem_write      = m0.write;
      mem_byteenable = m0.write ? m0.byteenable : '1;
      mem_writedata  = m0.writedata;
    end
  end

  assign m0.waitrequest = ~reset_n | (req0 & ~grant0);
  assign m1.waitrequest = ~reset_n | (req1 & ~grant1);

  // A command with both strobes high is a write and never returns data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend <= 1'b0;
      rd_id   <= 1'b0;
    end else begin
      rd_pend <= (grant0 & m0.read & ~m0.write) | (grant1 & m1.read & ~m1.write);
      rd_id   <= grant1;
    end
  end

  assign m0.readdatavalid = rd_pend & ~rd_id;
  assign m1.readdatavalid = rd_pend & rd_id;
  assign m0.readdata      = mem_readdata;
  assign m1.readdata      = mem_readdata;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb/tb_onchip_mem_arbiter.sv - randomized self-checking bench for onchip_mem_arbiter
// Reference model: shadow memory plus grant rules based on last winner and contested run length.
module tb_onchip_mem_arbiter;
  localparam int ADDR_W    = 15;
  localparam int DATA_W    = 32;
  localparam int BE_W      = 4;
  localparam int MAX_BURST = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) m0_bus ();
  onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) m1_bus ();

  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;

  onchip_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .m0(m0_bus),
    .m1(m1_bus),
    .mem_address(mem_address),
    .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect),
    .mem_write(mem_write),
    .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 16) return 32'hDEADBEEF;
    return {16'hA5A5, 16'(i)};
  endfunction

  function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] d,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Behavioural single-port RAM with registered read data.
  logic [31:0] ram [0:32767];
  logic        ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 32768; i++) ram[i] <= init_word(i);
      ram_ready <= 1'b1;
    end else if (mem_chipselect) begin
      if (mem_write) ram[mem_address] <= merge_be(ram[mem_address], mem_writedata, mem_byteenable);
      else           mem_readdata     <= ram[mem_address];
    end
  end

  wire [1:0] obs_wait = {m1_bus.waitrequest, m0_bus.waitrequest};
  wire [1:0] obs_rdv  = {m1_bus.readdatavalid, m0_bus.readdatavalid};
  logic [31:0] obs_rd [2];
  assign obs_rd[0] = m0_bus.readdata;
  assign obs_rd[1] = m1_bus.readdata;

  logic [31:0] shadow [0:32767];
  logic        c_rd [2];
  logic        c_wr [2];
  logic [14:0] c_addr [2];
  logic [3:0]  c_be [2];
  logic [31:0] c_data [2];
  logic        acc [2];
  logic        exp_rdv [2];
  logic [31:0] exp_rd [2];
  logic        s_rdv [2];
  logic [31:0] s_rd [2];
  int          wait_cnt [2];
  int          last_g;
  int          run;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    m0_bus.read = c_rd[0]; m0_bus.write = c_wr[0]; m0_bus.address = c_addr[0];
    m0_bus.byteenable = c_be[0]; m0_bus.writedata = c_data[0];
    m1_bus.read = c_rd[1]; m1_bus.write = c_wr[1]; m1_bus.address = c_addr[1];
    m1_bus.byteenable = c_be[1]; m1_bus.writedata = c_data[1];
  endtask

  task automatic issue(input int k, input logic rd, input logic wr, input logic [14:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    c_rd[k] = rd; c_wr[k] = wr; c_addr[k] = a; c_be[k] = be; c_data[k] = d;
  endtask

  task automatic model_reset();
    last_g = -1;
    run    = 0;
    for (int k = 0; k < 2; k++) begin
      exp_rdv[k] = 1'b0; wait_cnt[k] = 0; c_rd[k] = 1'b0; c_wr[k] = 1'b0; acc[k] = 1'b0;
    end
  endtask

  // One clock cycle: drive commands, predict and check at the falling edge, retire accepts.
  task automatic run_cycle();
    logic        r [2];
    logic        nrdv [2];
    logic [31:0] nrd [2];
    int          g;
    drive();
    @(negedge clk);
    for (int k = 0; k < 2; k++) r[k] = c_rd[k] | c_wr[k];
`ifdef MEMARB_FIXED_PRIO_EN
    g = r[1] ? 1 : (r[0] ? 0 : -1);
`else
    if (r[0] && r[1]) begin
      if (last_g < 0)           g = 1;
      else if (run < MAX_BURST) g = last_g;
      else                      g = 1 - last_g;
      run = (g == last_g) ? run + 1 : 1;
    end else if (r[0]) begin
      g = 0; run = 0;
    end else if (r[1]) begin
      g = 1; run = 0;
    end else begin
      g = -1; run = 0;
    end
`endif
    last_g = g;
    for (int k = 0; k < 2; k++) begin
      acc[k]   = (g == k);
      s_rdv[k] = obs_rdv[k];
      s_rd[k]  = obs_rd[k];
      check($sformatf("m%0d_waitrequest", k), obs_wait[k], r[k] && !acc[k]);
      check($sformatf("m%0d_readdatavalid", k), obs_rdv[k], exp_rdv[k]);
      if (exp_rdv[k]) check($sformatf("m%0d_readdata", k), obs_rd[k], exp_rd[k]);
      wait_cnt[k] = (r[k] && !acc[k]) ? wait_cnt[k] + 1 : 0;
`ifndef MEMARB_FIXED_PRIO_EN
      if (r[k]) check($sformatf("m%0d_wait_bound", k), wait_cnt[k] <= MAX_BURST, 1);
`endif
      nrdv[k] = acc[k] && c_rd[k] && !c_wr[k];
      nrd[k]  = shadow[c_addr[k]];
    end
    check("mem_chipselect", mem_chipselect, g >= 0);
    if (g >= 0) begin
      check("mem_address", mem_address, c_addr[g]);
      check("mem_write", mem_write, c_wr[g]);
      check("mem_byteenable", mem_byteenable, c_wr[g] ? c_be[g] : 4'hF);
      if (c_wr[g]) begin
        check("mem_writedata", mem_writedata, c_data[g]);
        shadow[c_addr[g]] = merge_be(shadow[c_addr[g]], c_data[g], c_be[g]);
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      exp_rdv[k] = nrdv[k];
      exp_rd[k]  = nrd[k];
      if (acc[k]) begin c_rd[k] = 1'b0; c_wr[k] = 1'b0; end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((c_rd[0] || c_wr[0] || c_rd[1] || c_wr[1]) && n < 40) begin
      run_cycle();
      n++;
    end
    check("drain_timeout", c_rd[0] || c_wr[0] || c_rd[1] || c_wr[1], 0);
    run_cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m0_waitrequest"}, obs_wait[0], 1);
    check({tag, "_m1_waitrequest"}, obs_wait[1], 1);
    check({tag, "_m0_readdatavalid"}, obs_rdv[0], 0);
    check({tag, "_m1_readdatavalid"}, obs_rdv[1], 0);
    check({tag, "_mem_chipselect"}, mem_chipselect, 0);
    check({tag, "_mem_write"}, mem_write, 0);
  endtask

  initial begin
    int first0, n1_first8, kind, dens;
    int dens_tab [5];
    dens_tab = '{30, 90, 100, 60, 95};
    for (int i = 0; i < 32768; i++) shadow[i] = init_word(i);
    for (int k = 0; k < 2; k++) begin
      c_addr[k] = '0; c_be[k] = '0; c_data[k] = '0;
    end
    model_reset();

    // Reset: commands held high must stay stalled and the RAM port idle.
    issue(0, 1, 0, 15'h10, 4'h0, 0);
    issue(1, 1, 1, 15'h20, 4'hF, 32'h1);
    drive();
    repeat (2) begin
      @(negedge clk);
      check_reset_outputs("reset");
    end
    model_reset();
    drive();
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single m0 read of the preloaded word.
    issue(0, 1, 0, 15'h10, 4'h0, 0);
    run_cycle();
    check("t1_accept", acc[0], 1);
    run_cycle();
    check("t1_rdv0", s_rdv[0], 1);
    check("t1_rdv1", s_rdv[1], 0);
    check("t1_data", s_rd[0], 32'hDEADBEEF);

    // Partial write by m1 then read back by m0.
    issue(1, 0, 1, 15'h100, 4'b0011, 32'h12345678);
    run_cycle();
    check("t2_write_accept", acc[1], 1);
    issue(0, 1, 0, 15'h100, 4'h0, 0);
    run_cycle();
    check("t2_read_accept", acc[0], 1);
    run_cycle();
    check("t2_data", s_rd[0], 32'hA5A55678);

    // Continuous reads from both, starting from IDLE.
    run_cycle();
    first0 = -1;
    n1_first8 = 0;
    for (int i = 0; i < 48; i++) begin
      for (int k = 0; k < 2; k++)
        if (!c_rd[k] && !c_wr[k]) issue(k, 1, 0, 15'($urandom_range(0, 63)), 4'h0, 0);
      run_cycle();
      if (acc[0] && first0 < 0) first0 = i;
      if (acc[1] && i < 8) n1_first8++;
    end
    check("t3_m1_first_burst", n1_first8, 8);
`ifdef MEMARB_FIXED_PRIO_EN
    check("t3_m0_starved", first0, -1);
    c_rd[1] = 1'b0;
    run_cycle();
    check("t3_m0_after_m1_drop", acc[0], 1);
`else
    check("t3_m0_first_wait", first0, 8);
`endif
    drain();

    // Asynchronous reset right after an accepted read.
    issue(0, 1, 0, 15'h10, 4'h0, 0);
    run_cycle();
    check("t4_accept", acc[0], 1);
    reset_n = 1'b0;
    issue(0, 1, 0, 15'h11, 4'h0, 0);
    issue(1, 1, 0, 15'h12, 4'h0, 0);
    drive();
    repeat (2) begin
      @(negedge clk);
      check_reset_outputs("t4");
    end
    model_reset();
    drive();
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    issue(0, 1, 0, 15'h10, 4'h0, 0);
    run_cycle();
    check("t4_post_accept", acc[0], 1);
    run_cycle();
    check("t4_post_data", s_rd[0], 32'hDEADBEEF);

    // Randomized traffic at several request densities.
    for (int i = 0; i < 2500; i++) begin
      dens = dens_tab[i / 500];
      for (int k = 0; k < 2; k++) begin
        if (!c_rd[k] && !c_wr[k] && $urandom_range(0, 99) < dens) begin
          kind = $urandom_range(0, 2);
          issue(k, kind != 1, kind != 0,
                ($urandom_range(0, 3) == 0) ? 15'($urandom_range(0, 24999))
                                            : 15'($urandom_range(0, 31)),
                4'($urandom), $urandom);
        end
      end
      run_cycle();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
